// File: rtl/sysctrl_gen_if.sv
// MCU byte-stream bus for sysctrl_gen.
// master: MCU side drives strobes/data; slave: controller replies.
interface sysctrl_gen_if;
   logic       data_in_strobe;
   logic       data_in_start;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (
      output data_in_strobe,
      output data_in_start,
      output data_in,
      input  data_out
   );

   modport slave (
      input  data_in_strobe,
      input  data_in_start,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/sysctrl_gen.sv
// System controller: framed MCU command decoder for leds, color,
// config regs, IO ports, interrupts and a streamed menu ROM.
// Ports: clk/reset_n, mcu (byte bus), int_*, buttons/leds/color,
// port_* (per-port slices), cfg_values/cfg_strobe, menu_addr/data.
module sysctrl_gen #(
   parameter logic [7:0] CORE_ID   = 8'h01,
   parameter int         NUM_PORTS = 2,
   parameter int         CFG_REGS  = 16,
   parameter int         MENU_AW   = 12
) (
   input  logic                     clk,
   input  logic                     reset_n,
   sysctrl_gen_if.slave             mcu,
   output logic                     int_out_n,
   input  logic [7:0]               int_in,
   output logic [7:0]               int_ack,
   input  logic [1:0]               buttons,
   output logic [1:0]               leds,
   output logic [23:0]              color,
   input  logic [32*NUM_PORTS-1:0]  port_status,
   input  logic [8*NUM_PORTS-1:0]   port_out_available,
   input  logic [8*NUM_PORTS-1:0]   port_out_data,
   output logic [NUM_PORTS-1:0]     port_out_strobe,
   input  logic [8*NUM_PORTS-1:0]   port_in_available,
   output logic [NUM_PORTS-1:0]     port_in_strobe,
   output logic [7:0]               port_in_data,
   output logic [8*CFG_REGS-1:0]    cfg_values,
   output logic [CFG_REGS-1:0]      cfg_strobe,
   output logic [MENU_AW-1:0]       menu_addr,
   input  logic [7:0]               menu_data
);

   localparam logic [7:0] NP8 = 8'(NUM_PORTS);
   localparam logic [7:0] CR8 = 8'(CFG_REGS);

   logic [7:0]              cnt_q, cnt_d;
   logic [7:0]              cmd_q, cmd_d;
   logic [7:0]              id_q, id_d;
   logic [7:0]              sub_q, sub_d;
   logic [7:0]              pidx_q, pidx_d;
   logic [1:0]              leds_q, leds_d;
   logic [23:0]             color_q, color_d;
   logic [7:0]              ack_q, ack_d;
   logic                    sys_int_q, sys_int_d;
   logic                    cold_q, cold_d;
   logic [8*CFG_REGS-1:0]   cfg_q, cfg_d;
   logic [CFG_REGS-1:0]     cstb_q, cstb_d;
   logic [MENU_AW-1:0]      menu_q, menu_d;
   logic [7:0]              dout_q, dout_d;
   logic [7:0]              pind_q, pind_d;
   logic [NUM_PORTS-1:0]    postb_q, postb_d;
   logic [NUM_PORTS-1:0]    pistb_q, pistb_d;
   logic [NUM_PORTS-1:0]    edge_q, edge_d;

   logic [NUM_PORTS-1:0]    avail_nz;
   logic [7:0]              avail_map;
   logic                    pidx_ok;
   logic [31:0]             sel_status;
   logic [7:0]              sel_oav;
   logic [7:0]              sel_iav;
   logic [7:0]              sel_odata;
   logic [7:0]              din;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   assign din     = mcu.data_in;
   assign pidx_ok = pidx_q < NP8;

   // Per-port views; pidx selection is done by loop compare so an
   // out-of-range index simply selects nothing.
   always_comb begin
      avail_map  = '0;
      sel_status = '0;
      sel_oav    = '0;
      sel_iav    = '0;
      sel_odata  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         avail_nz[p]  = |port_out_available[p*8 +: 8];
         avail_map[p] = avail_nz[p];
         if (pidx_q == 8'(p)) begin
            sel_status = port_status[p*32 +: 32];
            sel_oav    = port_out_available[p*8 +: 8];
            sel_iav    = port_in_available[p*8 +: 8];
            sel_odata  = port_out_data[p*8 +: 8];
         end
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      id_d      = id_q;
      sub_d     = sub_q;
      pidx_d    = pidx_q;
      leds_d    = leds_q;
      color_d   = color_q;
      ack_d     = '0;
      cold_d    = cold_q;
      cfg_d     = cfg_q;
      cstb_d    = '0;
      menu_d    = menu_q;
      dout_d    = dout_q;
      pind_d    = pind_q;
      postb_d   = '0;
      pistb_d   = '0;
      edge_d    = avail_nz;

      // Clear first so a coincident rising edge wins.
      sys_int_d = sys_int_q;
      if (ack_q[0]) sys_int_d = 1'b0;
      if (|(avail_nz & ~edge_q)) sys_int_d = 1'b1;

      if (mcu.data_in_strobe) begin
         if (mcu.data_in_start) begin
            cmd_d = din;
            cnt_d = 8'd1;
         end else if (cnt_q != 8'd0 && cmd_q <= 8'd8) begin
            cnt_d  = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
            dout_d = '0;
            unique case (cmd_q)
               8'd0: begin
                  case (cnt_q)
                     8'd1:    dout_d = 8'h5c;
                     8'd2:    dout_d = 8'h42;
                     8'd3:    dout_d = CORE_ID;
                     default: dout_d = '0;
                  endcase
               end
               8'd1: begin
                  if (cnt_q == 8'd1) leds_d = din[1:0];
               end
               8'd2: begin
                  case (cnt_q)
                     8'd1:    color_d[15:8]  = rev8(din);
                     8'd2:    color_d[7:0]   = rev8(din);
                     8'd3:    color_d[23:16] = rev8(din);
                     default: ;
                  endcase
               end
               8'd3: dout_d = {6'b0, buttons};
               8'd4: begin
                  if (cnt_q == 8'd1) begin
                     id_d = din;
                  end else if (cnt_q == 8'd2 && id_q < CR8) begin
                     for (int r = 0; r < CFG_REGS; r++) begin
                        if (id_q == 8'(r)) begin
                           cfg_d[r*8 +: 8] = din;
                           cstb_d[r]       = 1'b1;
                        end
                     end
                  end
               end
               8'd5: begin
                  if (cnt_q == 8'd1) ack_d = din;
                  dout_d = {int_in[7:1], sys_int_q};
               end
               8'd6: begin
                  case (cnt_q)
                     8'd1: begin
                        dout_d = {6'b0, |avail_nz, cold_q};
                        cold_d = 1'b0;
                     end
                     8'd2:    dout_d = avail_map;
                     default: dout_d = '0;
                  endcase
               end
               8'd7: begin
                  if (cnt_q == 8'd1) begin
                     sub_d  = din;
                     dout_d = NP8;
                  end else if (cnt_q == 8'd2) begin
                     pidx_d = din;
                     dout_d = (din < NP8) ? 8'h00 : 8'hff;
                  end else if (pidx_ok) begin
                     case (sub_q)
                        8'd0: begin
                           case (cnt_q)
                              8'd3:    dout_d = sel_oav;
                              8'd4:    dout_d = sel_iav;
                              8'd5:    dout_d = sel_status[31:24];
                              8'd6:    dout_d = sel_status[23:16];
                              8'd7:    dout_d = sel_status[15:8];
                              8'd8:    dout_d = sel_status[7:0];
                              default: dout_d = '0;
                           endcase
                        end
                        8'd1: begin
                           dout_d = sel_odata;
                           for (int p = 0; p < NUM_PORTS; p++)
                              if (pidx_q == 8'(p)) postb_d[p] = din[0];
                        end
                        8'd2: begin
                           pind_d = din;
                           for (int p = 0; p < NUM_PORTS; p++)
                              if (pidx_q == 8'(p)) pistb_d[p] = 1'b1;
                        end
                        default: dout_d = '0;
                     endcase
                  end
               end
               8'd8: begin
                  // ROM has 1-cycle latency: address is primed on
                  // byte 1 and each later byte consumes and advances.
                  if (cnt_q == 8'd1) begin
                     menu_d = '0;
                  end else begin
                     dout_d = menu_data;
                     menu_d = menu_q + MENU_AW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         cmd_q     <= '0;
         id_q      <= '0;
         sub_q     <= '0;
         pidx_q    <= '0;
         leds_q    <= '0;
         color_q   <= '0;
         ack_q     <= '0;
         sys_int_q <= 1'b1;
         cold_q    <= 1'b1;
         cfg_q     <= '0;
         cstb_q    <= '0;
         menu_q    <= '0;
         dout_q    <= '0;
         pind_q    <= '0;
         postb_q   <= '0;
         pistb_q   <= '0;
         edge_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         id_q      <= id_d;
         sub_q     <= sub_d;
         pidx_q    <= pidx_d;
         leds_q    <= leds_d;
         color_q   <= color_d;
         ack_q     <= ack_d;
         sys_int_q <= sys_int_d;
         cold_q    <= cold_d;
         cfg_q     <= cfg_d;
         cstb_q    <= cstb_d;
         menu_q    <= menu_d;
         dout_q    <= dout_d;
         pind_q    <= pind_d;
         postb_q   <= postb_d;
         pistb_q   <= pistb_d;
         edge_q    <= edge_d;
      end
   end

   assign mcu.data_out    = dout_q;
   assign int_out_n       = ~((|int_in) | sys_int_q);
   assign int_ack         = ack_q;
   assign leds            = leds_q;
   assign color           = color_q;
   assign port_out_strobe = postb_q;
   assign port_in_strobe  = pistb_q;
   assign port_in_data    = pind_q;
   assign cfg_values      = cfg_q;
   assign cfg_strobe      = cstb_q;
   assign menu_addr       = menu_q;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Directed bench for sysctrl_gen: frames sent over the MCU bus,
// replies and side effects checked against hand-computed values.
module tb_sysctrl_gen;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        int_out_n;
   logic [7:0]  int_in;
   logic [7:0]  int_ack;
   logic [1:0]  buttons;
   logic [1:0]  leds;
   logic [23:0] color;
   logic [63:0] port_status;
   logic [15:0] port_out_available;
   logic [15:0] port_out_data;
   logic [1:0]  port_out_strobe;
   logic [15:0] port_in_available;
   logic [1:0]  port_in_strobe;
   logic [7:0]  port_in_data;
   logic [127:0] cfg_values;
   logic [15:0] cfg_strobe;
   logic [11:0] menu_addr;
   logic [7:0]  menu_data;

   int tests = 0;
   int failed = 0;

   logic [7:0]  r_dout, r_ack;
   logic [15:0] r_cstb;
   logic [1:0]  r_pos, r_pis;

   sysctrl_gen_if bus ();

   sysctrl_gen dut (
      .clk(clk), .reset_n(reset_n), .mcu(bus.slave),
      .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
      .buttons(buttons), .leds(leds), .color(color),
      .port_status(port_status),
      .port_out_available(port_out_available),
      .port_out_data(port_out_data),
      .port_out_strobe(port_out_strobe),
      .port_in_available(port_in_available),
      .port_in_strobe(port_in_strobe),
      .port_in_data(port_in_data),
      .cfg_values(cfg_values), .cfg_strobe(cfg_strobe),
      .menu_addr(menu_addr), .menu_data(menu_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] romf(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], 4'h3};
   endfunction

   always_ff @(posedge clk) menu_data <= romf(menu_addr);

   task automatic xfer(input logic st, input logic [7:0] b);
      @(negedge clk);
      bus.data_in_strobe = 1'b1;
      bus.data_in_start  = st;
      bus.data_in        = b;
      @(negedge clk);
      bus.data_in_strobe = 1'b0;
      bus.data_in_start  = 1'b0;
      r_dout = bus.data_out;
      r_ack  = int_ack;
      r_cstb = cfg_strobe;
      r_pos  = port_out_strobe;
      r_pis  = port_in_strobe;
      @(negedge clk);
   endtask

   task automatic test_reset;
      tests++;
      if (bus.data_out !== 8'h00) begin
         failed++; $display("FAIL rst_dout got %h want 00", bus.data_out);
      end
      tests++;
      if ({leds, color, int_ack} !== 34'h0) begin
         failed++; $display("FAIL rst_outs got %h want 0", {leds, color, int_ack});
      end
      tests++;
      if (cfg_values !== 128'h0 || menu_addr !== 12'h0) begin
         failed++; $display("FAIL rst_cfg_menu got %h/%h want 0/0", cfg_values, menu_addr);
      end
      tests++;
      if ({port_out_strobe, port_in_strobe, cfg_strobe, port_in_data} !== 28'h0) begin
         failed++; $display("FAIL rst_strobes got %h want 0",
            {port_out_strobe, port_in_strobe, cfg_strobe, port_in_data});
      end
      tests++;
      if (int_out_n !== 1'b0) begin
         failed++; $display("FAIL rst_int_out_n got %b want 0", int_out_n);
      end
   endtask

   task automatic test_cmd0;
      logic [7:0] exp [3];
      exp[0] = 8'h5c; exp[1] = 8'h42; exp[2] = 8'h01;
      xfer(1'b1, 8'h00);
      for (int i = 0; i < 3; i++) begin
         xfer(1'b0, 8'h00);
         tests++;
         if (r_dout !== exp[i]) begin
            failed++; $display("FAIL cmd0_b%0d got %h want %h", i + 1, r_dout, exp[i]);
         end
      end
   endtask

   task automatic test_int;
      xfer(1'b1, 8'h05);
      xfer(1'b0, 8'h01);
      tests++;
      if (r_dout !== 8'h01 || r_ack !== 8'h01) begin
         failed++; $display("FAIL cmd5_ack got %h/%h want 01/01", r_dout, r_ack);
      end
      tests++;
      if (int_out_n !== 1'b1 || int_ack !== 8'h00) begin
         failed++; $display("FAIL int_clear got %b/%h want 1/00", int_out_n, int_ack);
      end
      int_in = 8'h84;
      #1;
      tests++;
      if (int_out_n !== 1'b0) begin
         failed++; $display("FAIL int_in_comb got %b want 0", int_out_n);
      end
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h84) begin
         failed++; $display("FAIL cmd5_status got %h want 84", r_dout);
      end
      int_in = 8'h00;
      xfer(1'b1, 8'h06);
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h01) begin
         failed++; $display("FAIL cmd6_cold got %h want 01", r_dout);
      end
      xfer(1'b1, 8'h06);
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h00) begin
         failed++; $display("FAIL cmd6_cold_clr got %h want 00", r_dout);
      end
   endtask

   task automatic test_leds_color;
      buttons = 2'b01;
      xfer(1'b1, 8'h01);
      xfer(1'b0, 8'h02);
      tests++;
      if (leds !== 2'b10) begin
         failed++; $display("FAIL leds got %b want 10", leds);
      end
      xfer(1'b1, 8'h03);
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h01) begin
         failed++; $display("FAIL buttons got %h want 01", r_dout);
      end
      xfer(1'b1, 8'h02);
      xfer(1'b0, 8'h01);
      xfer(1'b0, 8'h80);
      xfer(1'b0, 8'h0f);
      tests++;
      if (color !== 24'hf08001) begin
         failed++; $display("FAIL color got %h want f08001", color);
      end
   endtask

   task automatic test_ports;
      @(negedge clk);
      port_out_available[15:8] = 8'h03;
      @(negedge clk);
      tests++;
      if (int_out_n !== 1'b0) begin
         failed++; $display("FAIL port_edge_int got %b want 0", int_out_n);
      end
      xfer(1'b1, 8'h06);
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h02) begin
         failed++; $display("FAIL cmd6_b1 got %h want 02", r_dout);
      end
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h02) begin
         failed++; $display("FAIL cmd6_map got %h want 02", r_dout);
      end
      xfer(1'b1, 8'h07);
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h02) begin
         failed++; $display("FAIL cmd7_nports got %h want 02", r_dout);
      end
      xfer(1'b0, 8'h01);
      tests++;
      if (r_dout !== 8'h00) begin
         failed++; $display("FAIL cmd7_type got %h want 00", r_dout);
      end
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h03) begin
         failed++; $display("FAIL cmd7_oav got %h want 03", r_dout);
      end
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h44) begin
         failed++; $display("FAIL cmd7_iav got %h want 44", r_dout);
      end
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'hde) begin
         failed++; $display("FAIL cmd7_st3 got %h want de", r_dout);
      end
      xfer(1'b0, 8'h00);
      xfer(1'b0, 8'h00);
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'hef) begin
         failed++; $display("FAIL cmd7_st0 got %h want ef", r_dout);
      end
      xfer(1'b1, 8'h07);
      xfer(1'b0, 8'h01);
      xfer(1'b0, 8'h00);
      xfer(1'b0, 8'h01);
      tests++;
      if (r_dout !== 8'h3c || r_pos !== 2'b01) begin
         failed++; $display("FAIL cmd7_sub1 got %h/%b want 3c/01", r_dout, r_pos);
      end
      xfer(1'b1, 8'h07);
      xfer(1'b0, 8'h02);
      xfer(1'b0, 8'h01);
      xfer(1'b0, 8'h99);
      tests++;
      if (port_in_data !== 8'h99 || r_pis !== 2'b10 || port_in_strobe !== 2'b00) begin
         failed++; $display("FAIL cmd7_sub2 got %h/%b want 99/10", port_in_data, r_pis);
      end
      xfer(1'b1, 8'h05);
      xfer(1'b0, 8'h01);
      tests++;
      if (int_out_n !== 1'b1) begin
         failed++; $display("FAIL port_int_ack got %b want 1", int_out_n);
      end
   endtask

   task automatic test_bad_pidx;
      xfer(1'b1, 8'h07);
      xfer(1'b0, 8'h02);
      xfer(1'b0, 8'h09);
      tests++;
      if (r_dout !== 8'hff) begin
         failed++; $display("FAIL bad_pidx_type got %h want ff", r_dout);
      end
      xfer(1'b0, 8'h55);
      tests++;
      if (r_dout !== 8'h00 || r_pis !== 2'b00 || port_in_data !== 8'h99) begin
         failed++; $display("FAIL bad_pidx_strb got %h/%b/%h want 00/00/99",
            r_dout, r_pis, port_in_data);
      end
   endtask

   task automatic test_cfg;
      xfer(1'b1, 8'h04);
      xfer(1'b0, 8'h05);
      xfer(1'b0, 8'ha7);
      tests++;
      if (cfg_values[47:40] !== 8'ha7 || r_cstb !== 16'h0020) begin
         failed++; $display("FAIL cfg_wr got %h/%h want a7/0020", cfg_values[47:40], r_cstb);
      end
      tests++;
      if (cfg_strobe !== 16'h0000) begin
         failed++; $display("FAIL cfg_pulse got %h want 0000", cfg_strobe);
      end
      xfer(1'b1, 8'h04);
      xfer(1'b0, 8'h10);
      xfer(1'b0, 8'h11);
      tests++;
      if (cfg_values !== {80'h0, 8'ha7, 40'h0} || r_cstb !== 16'h0) begin
         failed++; $display("FAIL cfg_oob got %h/%h want a7 at reg5 only/0",
            cfg_values, r_cstb);
      end
   endtask

   task automatic test_menu;
      xfer(1'b1, 8'h08);
      xfer(1'b0, 8'h00);
      for (int k = 0; k <= 4096; k++) begin
         xfer(1'b0, 8'h00);
         if (k == 0 || k == 1 || k == 4095 || k == 4096) begin
            tests++;
            if (r_dout !== romf(12'(k % 4096))) begin
               failed++; $display("FAIL menu_b%0d got %h want %h",
                  k, r_dout, romf(12'(k % 4096)));
            end
         end
      end
      tests++;
      if (menu_addr !== 12'h001) begin
         failed++; $display("FAIL menu_wrap got %h want 001", menu_addr);
      end
   endtask

   task automatic test_reset_mid;
      xfer(1'b1, 8'h01);
      xfer(1'b0, 8'h03);
      xfer(1'b1, 8'h08);
      xfer(1'b0, 8'h00);
      xfer(1'b0, 8'h00);
      xfer(1'b0, 8'h00);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if ({leds, color, bus.data_out, port_in_data} !== 42'h0) begin
         failed++; $display("FAIL mid_rst_outs got %h want 0",
            {leds, color, bus.data_out, port_in_data});
      end
      tests++;
      if (menu_addr !== 12'h0 || cfg_values !== 128'h0 || int_out_n !== 1'b0) begin
         failed++; $display("FAIL mid_rst_state got %h/%h/%b want 0/0/0",
            menu_addr, cfg_values, int_out_n);
      end
      @(negedge clk);
      reset_n = 1'b1;
      xfer(1'b0, 8'h00);
      tests++;
      if (r_dout !== 8'h00 || menu_addr !== 12'h0) begin
         failed++; $display("FAIL no_start got %h/%h want 00/000", r_dout, menu_addr);
      end
   endtask

   initial begin
      reset_n            = 1'b0;
      bus.data_in_strobe = 1'b0;
      bus.data_in_start  = 1'b0;
      bus.data_in        = 8'h00;
      int_in             = 8'h00;
      buttons            = 2'b00;
      port_status        = {32'hdeadbeef, 32'h01020304};
      port_out_available = 16'h0000;
      port_out_data      = 16'h773c;
      port_in_available  = 16'h4411;
      repeat (3) @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      @(negedge clk);
      test_cmd0();
      test_int();
      test_leds_color();
      test_ports();
      test_bad_pidx();
      test_cfg();
      test_menu();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
